// File: rtl/net_pkg.sv
// Shared network stream types used by the RX buffer, the TX path and the NIC stream logic.
package net_pkg;

  localparam int NET_DATA_W = 64;
  localparam int NET_KEEP_W = 8;

  typedef struct packed {
    logic [NET_DATA_W-1:0] data;
    logic [NET_KEEP_W-1:0] keep;
    logic                  last;
  } net_flit_t;

  typedef enum logic {
    RX_ACCEPT = 1'b0,
    RX_DROP   = 1'b1
  } rx_wr_state_e;

endpackage

// File: rtl/net_rx_buf_mem.sv
// Flit storage for the RX buffer: one synchronous write port, one asynchronous read port.
import net_pkg::*;

module net_rx_buf_mem #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  net_flit_t     wr_flit,
  input  logic [AW-1:0] rd_addr,
  output net_flit_t     rd_flit
);

  net_flit_t mem [DEPTH];

  // NOTE: storage is deliberately not reset; the parent gates the read data with out_valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_flit;
  end

  assign rd_flit = mem[rd_addr];

endmodule

// File: rtl/net_rx_buffer.sv
// Store-and-forward RX packet buffer: absorbs flits without backpressure, drops packets that
// do not fit, and presents only complete packets on a valid/ready stream.
import net_pkg::*;

module net_rx_buffer #(
  parameter int BUF_WORDS = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [NET_DATA_W-1:0] in_data,
  input  logic [NET_KEEP_W-1:0] in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NET_DATA_W-1:0] out_data,
  output logic [NET_KEEP_W-1:0] out_keep,
  output logic                  out_last,
  output logic [31:0]           drop_count,
  output logic [31:0]           pkt_count
);

  localparam int AW = $clog2(BUF_WORDS);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] CAPACITY = (AW + 1)'(BUF_WORDS);

  logic [AW:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0]  occupancy;
  logic         full, wr_en, rd_en;
  rx_wr_state_e state;
  net_flit_t    in_flit, rd_flit, out_flit;

  assign in_flit   = '{data: in_data, keep: in_keep, last: in_last};
  // One extra pointer bit distinguishes a full buffer from an empty one.
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == CAPACITY);
  assign wr_en     = in_valid && (state == RX_ACCEPT) && !full;

  assign out_valid = (rd_ptr != commit_ptr);
  assign rd_en     = out_valid && out_ready;
  assign out_flit  = out_valid ? rd_flit : '0;
  assign out_data  = out_flit.data;
  assign out_keep  = out_flit.keep;
  assign out_last  = out_flit.last;

  net_rx_buf_mem #(
    .DEPTH (BUF_WORDS),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_flit (in_flit),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_flit (rd_flit)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked block rather than the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      state      <= RX_ACCEPT;
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (in_valid) begin
        case (state)
          RX_ACCEPT: begin
            if (!full) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              if (in_last) begin
                commit_ptr <= wr_ptr + PTR_ONE;
                pkt_count  <= pkt_count + 32'd1;
              end
            end else begin
              // Rewind over the partial packet; the rest of it is swallowed in RX_DROP.
              wr_ptr <= commit_ptr;
              if (drop_count != '1) drop_count <= drop_count + 32'd1;
              if (!in_last) state <= RX_DROP;
            end
          end
          RX_DROP: begin
            if (in_last) state <= RX_ACCEPT;
          end
          default: state <= RX_ACCEPT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_net_rx_buffer.sv
// Self-checking bench for net_rx_buffer: directed scenarios plus randomized traffic against a
// queue-based packet model, run on an 8-entry and a 16-entry instance.
import net_pkg::*;

module tb_net_rx_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        v8, v16, l8, l16;
  logic [63:0] d8, d16;
  logic [7:0]  k8, k16;
  logic [31:0] dc8, dc16, pc8, pc16;

  logic        o_valid, o_last;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic [31:0] o_drop, o_pkts;

  int n_tests = 0;
  int n_fail  = 0;

  net_flit_t   cq[$];
  net_flit_t   pq[$];
  int unsigned m_drops, m_pkts;
  bit          m_dropping;

  always #5 clock = ~clock;

  net_rx_buffer #(.BUF_WORDS(8)) u_dut8 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid && !sel),
    .in_data    (in_data),
    .in_keep    (in_keep),
    .in_last    (in_last),
    .out_valid  (v8),
    .out_ready  (out_ready && !sel),
    .out_data   (d8),
    .out_keep   (k8),
    .out_last   (l8),
    .drop_count (dc8),
    .pkt_count  (pc8)
  );

  net_rx_buffer #(.BUF_WORDS(16)) u_dut16 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid && sel),
    .in_data    (in_data),
    .in_keep    (in_keep),
    .in_last    (in_last),
    .out_valid  (v16),
    .out_ready  (out_ready && sel),
    .out_data   (d16),
    .out_keep   (k16),
    .out_last   (l16),
    .drop_count (dc16),
    .pkt_count  (pc16)
  );

  assign o_valid = sel ? v16  : v8;
  assign o_data  = sel ? d16  : d8;
  assign o_keep  = sel ? k16  : k8;
  assign o_last  = sel ? l16  : l8;
  assign o_drop  = sel ? dc16 : dc8;
  assign o_pkts  = sel ? pc16 : pc8;

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic net_flit_t make_flit(input logic last, input logic [7:0] keep);
    net_flit_t f;
    f.data = {$urandom, $urandom};
    f.keep = keep;
    f.last = last;
    return f;
  endfunction

  // Model: committed-unread flits in cq, partial packet in pq; occupancy is their sum.
  task automatic cycle(input logic v, input net_flit_t f, input logic rdy);
    net_flit_t exp_f;
    bit        full;
    int        depth;
    in_valid  = v;
    in_data   = f.data;
    in_keep   = f.keep;
    in_last   = f.last;
    out_ready = rdy;
    #1;
    exp_f = (cq.size() != 0) ? cq[0] : '0;
    check("out_valid", 73'(o_valid), 73'(cq.size() != 0));
    check("out_flit", {o_data, o_keep, o_last}, exp_f);
    check("drop_count", 73'(o_drop), 73'(m_drops));
    check("pkt_count", 73'(o_pkts), 73'(m_pkts));
    depth = sel ? 16 : 8;
    full  = (cq.size() + pq.size()) == depth;
    if (rdy && cq.size() != 0) void'(cq.pop_front());
    if (v) begin
      if (m_dropping) begin
        if (f.last) m_dropping = 1'b0;
      end else if (!full) begin
        pq.push_back(f);
        if (f.last) begin
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
          m_pkts++;
        end
      end else begin
        pq.delete();
        if (m_drops != 32'hFFFF_FFFF) m_drops++;
        if (!f.last) m_dropping = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
  endtask

  task automatic send_pkt(input int len, input bit rand_rdy, input logic rdy, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 99) < gap_pct)
        cycle(1'b0, '0, rand_rdy ? logic'($urandom_range(0, 1)) : rdy);
      cycle(1'b1, make_flit(i == len - 1, 8'($urandom)), rand_rdy ? logic'($urandom_range(0, 1)) : rdy);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    cq.delete();
    pq.delete();
    m_drops    = 0;
    m_pkts     = 0;
    m_dropping = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    do_reset();
    idle(2, 1'b1);

    // 3-flit packet with streaming consumer; partial last-flit keep mask.
    cycle(1'b1, make_flit(1'b0, 8'hFF), 1'b1);
    cycle(1'b1, make_flit(1'b0, 8'hFF), 1'b1);
    cycle(1'b1, make_flit(1'b1, 8'h0F), 1'b1);
    check("t1_valid_after_last", 73'(o_valid), 73'(1));
    idle(4, 1'b1);
    check("t1_pkt_count", 73'(o_pkts), 73'(1));

    // Stalled consumer: 2-flit packet committed, 7-flit packet overflows on its last flit.
    do_reset();
    send_pkt(2, 1'b0, 1'b0, 0);
    send_pkt(7, 1'b0, 1'b0, 0);
    check("t2_drop_count", 73'(o_drop), 73'(1));
    idle(5, 1'b1);
    check("t2_drained", 73'(o_valid), 73'(0));

    // Oversize packets: 9 flits drops on its last, 11 flits with gaps passes through DROP.
    do_reset();
    send_pkt(9, 1'b0, 1'b0, 0);
    send_pkt(11, 1'b0, 1'b0, 30);
    send_pkt(2, 1'b0, 1'b0, 0);
    idle(4, 1'b1);
    check("t3_drop_count", 73'(o_drop), 73'(2));
    check("t3_pkt_count", 73'(o_pkts), 73'(1));

    // Back-to-back single-flit packets at full rate.
    do_reset();
    for (int i = 0; i < 20; i++) send_pkt(1, 1'b0, 1'b1, 0);
    idle(2, 1'b1);
    check("t4_no_drops", 73'(o_drop), 73'(0));
    check("t4_pkt_count", 73'(o_pkts), 73'(20));

    // Randomized traffic on the 16-entry instance with a random consumer.
    sel = 1'b1;
    do_reset();
    for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, 6), 1'b1, 1'b0, 20);
    idle(24, 1'b1);
    check("t5_drained", 73'(o_valid), 73'(0));

    // Reset with two packets buffered and a third in flight.
    sel = 1'b0;
    do_reset();
    send_pkt(2, 1'b0, 1'b0, 0);
    send_pkt(2, 1'b0, 1'b0, 0);
    cycle(1'b1, make_flit(1'b0, 8'hFF), 1'b0);
    cycle(1'b1, make_flit(1'b0, 8'hFF), 1'b0);
    do_reset();
    check("t6_valid_after_reset", 73'(o_valid), 73'(0));
    check("t6_pkts_after_reset", 73'(o_pkts), 73'(0));
    cycle(1'b1, make_flit(1'b0, 8'hFF), 1'b0);
    cycle(1'b1, make_flit(1'b1, 8'h03), 1'b0);
    check("t6_trailing_committed", 73'(o_pkts), 73'(1));
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
